// File: rtl/gshare_btb_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : gshare_btb_predictor
//  Purpose  : Fetch-stage branch predictor. A PHT of saturating counters,
//             indexed bimodally or gshare-style, is combined with a
//             direct-mapped BTB. It gives a zero-latency taken/target
//             prediction for fetch_pc_i. Training happens at execute
//             resolution. The block also keeps saturating branch and
//             mispredict statistics.
//  Ports    : clk, rst                  - clock, synchronous active-high reset
//             fetch_pc_i                - PC looked up this cycle
//             predict_taken_o           - redirect fetch to predicted_target_o
//             predicted_target_o        - BTB target (0 on miss)
//             btb_hit_o                 - valid BTB entry with matching tag
//             fetch_ghr_o               - history used for this lookup
//             execute_*_i               - resolution/training interface
//             branch_count_o            - resolved branches+jumps (saturating)
//             mispredict_count_o        - mispredictions (saturating)
//  Revision : 1.0 - initial release
// ============================================================================
module gshare_btb_predictor #(
    parameter int PHT_ENTRIES = 256,
    parameter int BTB_ENTRIES = 64,
    parameter int GHR_BITS    = 8,
    parameter int CTR_BITS    = 2,
    parameter int MODE        = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         fetch_pc_i,
    output logic                predict_taken_o,
    output logic [31:0]         predicted_target_o,
    output logic                btb_hit_o,
    output logic [GHR_BITS-1:0] fetch_ghr_o,
    input  logic                execute_valid_i,
    input  logic [31:0]         execute_pc_i,
    input  logic                execute_is_jump_i,
    input  logic                execute_taken_i,
    input  logic [31:0]         execute_target_i,
    input  logic [GHR_BITS-1:0] execute_ghr_i,
    input  logic                execute_mispredict_i,
    output logic [31:0]         branch_count_o,
    output logic [31:0]         mispredict_count_o
);

    localparam int c_PIDX_W = $clog2(PHT_ENTRIES);
    localparam int c_BIDX_W = $clog2(BTB_ENTRIES);
    localparam int c_TAG_W  = 32 - c_BIDX_W - 2;
    localparam logic [CTR_BITS-1:0] c_CTR_MAX  = '1;
    // Weakly not-taken: 2^(CTR_BITS-1)-1, which is 0 for a 1-bit counter.
    localparam logic [CTR_BITS-1:0] c_CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    // Storage
    logic [CTR_BITS-1:0] r_pht       [PHT_ENTRIES];
    logic [BTB_ENTRIES-1:0] r_btbValid;
    logic [BTB_ENTRIES-1:0] r_btbJump;
    logic [c_TAG_W-1:0]  r_btbTag    [BTB_ENTRIES];
    logic [31:0]         r_btbTarget [BTB_ENTRIES];
    logic [GHR_BITS-1:0] r_ghr;
    logic [31:0]         r_branchCount;
    logic [31:0]         r_mispredictCount;

    // Fetch-side lookup (combinational, reads pre-update state)
    logic [c_PIDX_W-1:0] w_fetchPIdx;
    logic [c_BIDX_W-1:0] w_fetchBIdx;
    logic [c_TAG_W-1:0]  w_fetchTag;
    logic                w_fetchHit;

    assign w_fetchPIdx = fetch_pc_i[c_PIDX_W+1:2]
                       ^ ((MODE != 0) ? c_PIDX_W'(r_ghr) : '0);
    assign w_fetchBIdx = fetch_pc_i[c_BIDX_W+1:2];
    assign w_fetchTag  = fetch_pc_i[31:c_BIDX_W+2];
    assign w_fetchHit  = r_btbValid[w_fetchBIdx] && (r_btbTag[w_fetchBIdx] == w_fetchTag);

    assign btb_hit_o          = w_fetchHit;
    assign predicted_target_o = w_fetchHit ? r_btbTarget[w_fetchBIdx] : 32'h0;
    assign predict_taken_o    = w_fetchHit
                              & (r_btbJump[w_fetchBIdx] | r_pht[w_fetchPIdx][CTR_BITS-1]);
    assign fetch_ghr_o        = r_ghr;
    assign branch_count_o     = r_branchCount;
    assign mispredict_count_o = r_mispredictCount;

    // Execute-side training. The PHT index uses the history captured at
    // fetch time, not the live GHR, so training hits the counter that
    // made the prediction.
    logic [c_PIDX_W-1:0] w_exePIdx;
    logic [c_BIDX_W-1:0] w_exeBIdx;
    logic [CTR_BITS-1:0] w_ctrOld;
    logic [CTR_BITS-1:0] w_ctrNext;
    logic [GHR_BITS:0]   w_ghrShift;
    logic                w_exeCond;
    logic                w_exeAlloc;

    assign w_exePIdx  = execute_pc_i[c_PIDX_W+1:2]
                      ^ ((MODE != 0) ? c_PIDX_W'(execute_ghr_i) : '0);
    assign w_exeBIdx  = execute_pc_i[c_BIDX_W+1:2];
    assign w_ctrOld   = r_pht[w_exePIdx];
    // Shifting through one extra bit covers GHR_BITS=1 without a special case.
    assign w_ghrShift = {r_ghr, execute_taken_i};
    assign w_exeCond  = execute_valid_i & ~execute_is_jump_i;
    assign w_exeAlloc = execute_valid_i & execute_taken_i;

    always_comb begin
        w_ctrNext = w_ctrOld;
        if (execute_taken_i) begin
            if (w_ctrOld != c_CTR_MAX) w_ctrNext = w_ctrOld + CTR_BITS'(1);
        end else begin
            if (w_ctrOld != '0) w_ctrNext = w_ctrOld - CTR_BITS'(1);
        end
    end

    // State that needs a reset value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_ENTRIES; i++) r_pht[i] <= c_CTR_INIT;
            r_btbValid        <= '0;
            r_ghr             <= '0;
            r_branchCount     <= '0;
            r_mispredictCount <= '0;
        end else if (execute_valid_i) begin
            if (w_exeCond) begin
                r_pht[w_exePIdx] <= w_ctrNext;
                r_ghr            <= w_ghrShift[GHR_BITS-1:0];
            end
            if (w_exeAlloc) r_btbValid[w_exeBIdx] <= 1'b1;
            if (r_branchCount != 32'hFFFF_FFFF)
                r_branchCount <= r_branchCount + 32'd1;
            if (execute_mispredict_i && (r_mispredictCount != 32'hFFFF_FFFF))
                r_mispredictCount <= r_mispredictCount + 32'd1;
        end
    end

    // BTB payload; gated by the valid bits, so no reset is needed.
    always_ff @(posedge clk) begin
        if (!rst && w_exeAlloc) begin
            r_btbTag[w_exeBIdx]    <= execute_pc_i[31:c_BIDX_W+2];
            r_btbTarget[w_exeBIdx] <= execute_target_i;
            r_btbJump[w_exeBIdx]   <= execute_is_jump_i;
        end
    end

    // Address bits [1:0] are ignored; history input is unused in bimodal mode.
    logic w_unused;
    assign w_unused = ^{fetch_pc_i[1:0], execute_pc_i[1:0], execute_ghr_i};

endmodule
`default_nettype wire

// File: tb/tb_gshare_btb_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gshare_btb_predictor
//  Purpose  : Directed self-checking bench. dut0 uses bimodal indexing and
//             dut1 uses gshare indexing with a 2-bit history. Both share
//             the same input stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gshare_btb_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] fetchPc = '0;
    logic        exeValid = 1'b0;
    logic [31:0] exePc = '0;
    logic        exeJump = 1'b0;
    logic        exeTaken = 1'b0;
    logic [31:0] exeTarget = '0;
    logic [7:0]  exeGhr8 = '0;
    logic [1:0]  exeGhr2 = '0;
    logic        exeMis = 1'b0;

    logic        taken0, hit0, taken1, hit1;
    logic [31:0] target0, target1, bCnt0, mCnt0, bCnt1, mCnt1;
    logic [7:0]  ghr0;
    logic [1:0]  ghr1;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    gshare_btb_predictor #(.PHT_ENTRIES(256), .BTB_ENTRIES(64), .GHR_BITS(8),
                           .CTR_BITS(2), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .fetch_pc_i(fetchPc),
        .predict_taken_o(taken0), .predicted_target_o(target0), .btb_hit_o(hit0),
        .fetch_ghr_o(ghr0), .execute_valid_i(exeValid), .execute_pc_i(exePc),
        .execute_is_jump_i(exeJump), .execute_taken_i(exeTaken),
        .execute_target_i(exeTarget), .execute_ghr_i(exeGhr8),
        .execute_mispredict_i(exeMis), .branch_count_o(bCnt0),
        .mispredict_count_o(mCnt0));

    gshare_btb_predictor #(.PHT_ENTRIES(256), .BTB_ENTRIES(64), .GHR_BITS(2),
                           .CTR_BITS(2), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .fetch_pc_i(fetchPc),
        .predict_taken_o(taken1), .predicted_target_o(target1), .btb_hit_o(hit1),
        .fetch_ghr_o(ghr1), .execute_valid_i(exeValid), .execute_pc_i(exePc),
        .execute_is_jump_i(exeJump), .execute_taken_i(exeTaken),
        .execute_target_i(exeTarget), .execute_ghr_i(exeGhr2),
        .execute_mispredict_i(exeMis), .branch_count_o(bCnt1),
        .mispredict_count_o(mCnt1));

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One resolution: inputs driven for exactly one rising edge.
    task automatic resolve(input logic [31:0] pc, input logic jump, input logic tk,
                           input logic [31:0] tgt, input logic [1:0] ghr, input logic mis);
        @(negedge clk);
        exeValid = 1'b1; exePc = pc; exeJump = jump; exeTaken = tk;
        exeTarget = tgt; exeGhr2 = ghr; exeGhr8 = 8'h00; exeMis = mis;
        @(negedge clk);
        exeValid = 1'b0; exeMis = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        fetchPc = pc;
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // 1: reset state
        doReset();
        lookup(32'h100);
        check("rst_taken", {31'd0, taken0}, 32'd0);
        check("rst_hit",   {31'd0, hit0},   32'd0);
        check("rst_target", target0, 32'd0);
        check("rst_bcnt",   bCnt0,   32'd0);
        check("rst_mcnt",   mCnt0,   32'd0);
        check("rst_ghr",    {24'd0, ghr0}, 32'd0);

        // 2: bimodal train 0x100 -> 0x80 (01->10), then two not-taken (->00)
        resolve(32'h100, 1'b0, 1'b1, 32'h80, 2'b00, 1'b1);
        lookup(32'h100);
        check("t2_hit",    {31'd0, hit0},   32'd1);
        check("t2_target", target0, 32'h80);
        check("t2_taken",  {31'd0, taken0}, 32'd1);
        resolve(32'h100, 1'b0, 1'b0, 32'h104, 2'b00, 1'b1);
        resolve(32'h100, 1'b0, 1'b0, 32'h104, 2'b00, 1'b0);
        lookup(32'h100);
        check("t2_nt_taken", {31'd0, taken0}, 32'd0);
        check("t2_nt_hit",   {31'd0, hit0},   32'd1);
        check("t2_ghr",      {24'd0, ghr0},   32'h04);
        check("t2_bcnt",     bCnt0, 32'd3);
        check("t2_mcnt",     mCnt0, 32'd2);

        // 3: saturation at 0x200 (01->10->11->11...), then one not-taken -> 10
        for (int i = 0; i < 5; i++)
            resolve(32'h200, 1'b0, 1'b1, 32'h900, 2'b00, (i == 0));
        resolve(32'h200, 1'b0, 1'b0, 32'h204, 2'b00, 1'b1);
        lookup(32'h200);
        check("t3_taken",  {31'd0, taken0}, 32'd1);
        check("t3_target", target0, 32'h900);
        check("t3_bcnt",   bCnt0, 32'd9);
        check("t3_mcnt",   mCnt0, 32'd4);
        check("t3_ghr",    {24'd0, ghr0}, 32'h3E);

        // 4: JAL 0x40 -> 0x400; history must not move
        resolve(32'h40, 1'b1, 1'b1, 32'h400, 2'b00, 1'b1);
        lookup(32'h40);
        check("t4_taken",  {31'd0, taken0}, 32'd1);
        check("t4_target", target0, 32'h400);
        check("t4_ghr",    {24'd0, ghr0}, 32'h3E);
        check("t4_bcnt",   bCnt0, 32'd10);

        // 6a: train 0x300 taken (01->10), then same-cycle NT update + lookup
        resolve(32'h300, 1'b0, 1'b1, 32'h700, 2'b00, 1'b1);
        @(negedge clk);
        fetchPc = 32'h300;
        exeValid = 1'b1; exePc = 32'h300; exeJump = 1'b0; exeTaken = 1'b0;
        exeTarget = 32'h304; exeGhr8 = 8'h00; exeGhr2 = 2'b00; exeMis = 1'b1;
        #1;
        check("t6_old_taken", {31'd0, taken0}, 32'd1);
        @(negedge clk);
        exeValid = 1'b0; exeMis = 1'b0;
        #1;
        check("t6_new_taken", {31'd0, taken0}, 32'd0);
        check("t6_new_hit",   {31'd0, hit0},   32'd1);

        // 6b: reset with a concurrent update; the update is dropped
        @(negedge clk);
        rst = 1'b1;
        exeValid = 1'b1; exePc = 32'h500; exeJump = 1'b0; exeTaken = 1'b1;
        exeTarget = 32'h600; exeMis = 1'b1;
        @(negedge clk);
        rst = 1'b0; exeValid = 1'b0; exeMis = 1'b0;
        lookup(32'h500);
        check("t6_rst_hit500", {31'd0, hit0}, 32'd0);
        lookup(32'h40);
        check("t6_rst_hit40",  {31'd0, hit0}, 32'd0);
        check("t6_rst_target", target0, 32'd0);
        check("t6_rst_bcnt",   bCnt0, 32'd0);
        check("t6_rst_mcnt",   mCnt0, 32'd0);
        check("t6_rst_ghr",    {24'd0, ghr0}, 32'd0);

        // 5: gshare, PC 0x104 (word 0x41). Taken under history 01 -> pidx 0x40,
        //    not-taken under history 10 -> pidx 0x43.
        resolve(32'h104, 1'b0, 1'b1, 32'h1000, 2'b01, 1'b1);
        resolve(32'h104, 1'b0, 1'b0, 32'h108,  2'b10, 1'b0);
        lookup(32'h104);
        check("t5_ghr10",       {30'd0, ghr1}, 32'd2);
        check("t5_h10_taken",   {31'd0, taken1}, 32'd0);
        check("t5_h10_hit",     {31'd0, hit1},   32'd1);
        // Move live history 10 -> 00 -> 01 using PC 0x800 (pidx 0x00)
        resolve(32'h800, 1'b0, 1'b0, 32'h804, 2'b00, 1'b0);
        resolve(32'h800, 1'b0, 1'b1, 32'hA00, 2'b00, 1'b0);
        lookup(32'h104);
        check("t5_ghr01",       {30'd0, ghr1}, 32'd1);
        check("t5_h01_taken",   {31'd0, taken1}, 32'd1);
        check("t5_h01_target",  target1, 32'h1000);
        // Alias 0x104 + 4*256: same PHT/BTB index, different tag
        lookup(32'h504);
        check("t5_alias_hit",    {31'd0, hit1},   32'd0);
        check("t5_alias_taken",  {31'd0, taken1}, 32'd0);
        check("t5_alias_target", target1, 32'd0);
        check("t5_bcnt",         bCnt1, 32'd4);
        check("t5_mcnt",         mCnt1, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
